regfile_wb: RTL
===============

Name: regfile_wb

Overview:
- Integer register file (x0..x31) for the RV32I core, at the receiving end of the writeback interface driven by the MEM/WB pipeline register.
- Accepts one writeback per cycle and serves two read ports to the ID stage.
- Read data is combinational, with same-cycle write-to-read bypass.
- After reset, a sequencer clears the array one register per cycle and holds ready low until clearing completes, so the array can map to RAM without a bulk reset.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, register address width
NREG, 32, number of registers; must equal 2**ADDR_W

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  reset, synchronous, active-high
wb_we  in  1  writeback enable (from MEM/WB wreg)
wb_waddr  in  ADDR_W  writeback destination register
wb_wdata  in  DATA_W  writeback data
re1  in  1  read port 1 enable
raddr1  in  ADDR_W  read port 1 address
rdata1  out  DATA_W  read port 1 data, combinational
re2  in  1  read port 2 enable
raddr2  in  ADDR_W  read port 2 address
rdata2  out  DATA_W  read port 2 data, combinational
ready  out  1  high when array is initialised and accepting writes

Behaviour:
- Reset is synchronous, active-high, on clk.
- State machine, two states: INIT and RUN.
- While rst=1:
  - state<=INIT, clr_idx<=1, ready<=0.
  - Array contents are not touched on these edges.
  - rdata1 and rdata2 read 0 combinationally.
- INIT, each rising edge with rst=0:
  - regs[clr_idx]<=0, then clr_idx<=clr_idx+1.
  - On the edge that clears index NREG-1: state<=RUN, ready<=1.
  - Result: ready rises on the (NREG-1)th rising edge after rst deasserts (31 edges by default).
  - Index 0 is never written; it is hardwired.
- Writes in INIT: wb_we is ignored and no array write occurs. The core stalls the pipeline while ready=0.
- Writes in RUN: if wb_we=1 and wb_waddr!=0, regs[wb_waddr]<=wb_wdata on the rising edge. Writes to x0 are discarded.
- Read port n (identical rules for both ports, evaluated in priority order):
  1. rst=1 or state=INIT -> 0.
  2. ren=0 -> 0.
  3. raddrn=0 -> 0.
  4. wb_we=1, wb_waddr==raddrn, state=RUN -> wb_wdata (same-cycle bypass; no WB->ID hazard stall is needed).
  5. Otherwise -> regs[raddrn].
- Both ports may read the same address simultaneously and see identical data, including the bypass case.
- Reset asserted mid-operation, in either state: returns to INIT on that edge, ready drops the same edge, and the full clear sequence reruns after deassertion. Prior contents are lost.
- Reset asserted mid-INIT: clr_idx restarts at 1.
- ready is registered, with no combinational path from any input.
- No X may propagate to rdata outputs for any enabled read after ready=1.

Optional Feature:
- Macro: REGFILE_DBG_EN.
- Defined: adds ports dbg_raddr (in, ADDR_W) and dbg_rdata (out, DATA_W).
  - dbg_rdata is registered: on each rising edge it takes regs[dbg_raddr], or 0 if dbg_raddr=0 or state=INIT.
  - No bypass, so it reflects array contents before the same-edge write.
  - Reset value 0.
  - Used by the trace/debug unit.
- Undefined: the ports do not exist and no extra logic is generated.
- Functional behaviour of all other ports is identical in both builds.

Test Plan:
- Reset init: hold rst=1 for 2 cycles, release. Required:
  - ready=0 through 30 edges, ready=1 after the 31st edge.
  - During INIT, re1=1 raddr1=5 -> rdata1=0.
  - wb_we=1 waddr=5 wdata=0xDEADBEEF during INIT, then re1=1 raddr1=5 after ready -> rdata1=0.
- Write/read: in RUN, write x3=0x12345678 at edge N; at cycle N+1, re1=1 raddr1=3 -> rdata1=0x12345678.
- Same-cycle bypass and disable:
  - wb_we=1 waddr=7 wdata=0xA5A5A5A5 with re1=re2=1 raddr1=raddr2=7 -> both rdata=0xA5A5A5A5 in that cycle.
  - re2=0 -> rdata2=0.
- x0 hardwire: write x0=0xFFFFFFFF with raddr1=0 in the same cycle -> rdata1=0 that cycle and every later cycle.
- Mid-run reset:
  - Write x10=0x55, assert rst for 1 cycle, release -> ready=0 for 30 edges.
  - After ready returns, x10 reads 0.
  - Assert rst again at edge 10 of INIT -> ready rises 31 edges after the second deassertion.
- Debug port (REGFILE_DBG_EN defined): write x4=0x99 at edge N with dbg_raddr=4 held.
  - dbg_rdata shows the old value 0 after edge N and 0x99 after edge N+1.
  - dbg_raddr=0 -> dbg_rdata=0.

Source files
------------

// File: rtl/regfile_wb.sv
// regfile_wb: RV32I integer register file with writeback port, two bypassed read ports, post-reset clear sequencer (optional debug read port via REGFILE_DBG_EN)
module regfile_wb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NREG   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_we,
    input  logic [ADDR_W-1:0] wb_waddr,
    input  logic [DATA_W-1:0] wb_wdata,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2,
    output logic              ready
`ifdef REGFILE_DBG_EN
    ,
    input  logic [ADDR_W-1:0] dbg_raddr,
    output logic [DATA_W-1:0] dbg_rdata
`endif
);
    typedef enum logic {INIT, RUN} state_t;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NREG - 1);
    state_t state;
    logic [ADDR_W-1:0] clr_idx;
    logic [DATA_W-1:0] regs [NREG];
    logic blocked;
    // sequencer: walk clr_idx from 1 to NREG-1, then raise ready and enter RUN
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= INIT;
            clr_idx <= ADDR_W'(1);
            ready   <= 1'b0;
        end else if (state == INIT) begin
            clr_idx <= clr_idx + 1'b1;
            if (clr_idx == LAST) begin
                state <= RUN;
                ready <= 1'b1;
            end
        end
    end
    // array has no reset so it can map to RAM; cleared by the sequencer, written by WB in RUN
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == INIT)
                regs[clr_idx] <= '0;
            else if (wb_we && wb_waddr != '0)
                regs[wb_waddr] <= wb_wdata;
        end
    end
    // read ports: zero while blocked/disabled/x0, else same-cycle WB bypass, else array
    always_comb begin
        blocked = rst || state == INIT;
        rdata1  = (blocked || !re1 || raddr1 == '0) ? '0 :
                  (wb_we && wb_waddr == raddr1) ? wb_wdata : regs[raddr1];
        rdata2  = (blocked || !re2 || raddr2 == '0) ? '0 :
                  (wb_we && wb_waddr == raddr2) ? wb_wdata : regs[raddr2];
    end
`ifdef REGFILE_DBG_EN
    // registered debug snoop of array contents, without bypass
    always_ff @(posedge clk) begin
        if (rst)
            dbg_rdata <= '0;
        else
            dbg_rdata <= (state == INIT || dbg_raddr == '0) ? '0 : regs[dbg_raddr];
    end
`endif
endmodule
